// File: rtl/alu_result_stage.sv
// Registered result stage behind the combinational ALU. It holds results and NZCV flags in a two-entry
// skid buffer, and it keeps the architectural status register, a sticky overflow bit and a delivered-result count.
module alu_result_stage #(
    parameter int Nbits = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [Nbits-1:0] IN_RESULT,
    input  logic             IN_CARRY,
    input  logic             IN_OVERFLOW,
    input  logic             IN_NEGATIVE,
    input  logic             IN_ZERO,
    input  logic             IN_UPDATE_FLAGS,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [Nbits-1:0] OUT_RESULT,
    output logic [3:0]       OUT_FLAGS,
    output logic [3:0]       STATUS_NZCV,
    output logic             STICKY_OVERFLOW,
    input  logic             CLEAR_STICKY,
    output logic [CNT_W-1:0] RESULT_COUNT,
    output logic [1:0]       DEBUG_STATE
);

    localparam int EW = Nbits + 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            accept;
    logic            deliver;
    logic [EW-1:0]   head_q;
    logic [EW-1:0]   skid_q;
    logic [EW-1:0]   in_entry;
    logic [3:0]      status_q;
    logic            sticky_q;
    logic [CNT_W-1:0] count_q;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high. The producer keeps
    // valid and its payload steady until that edge. IN_READY and OUT_VALID depend only on the registered state,
    // so there is no combinational path from OUT_READY to IN_READY.
    assign accept   = IN_VALID & IN_READY;
    assign deliver  = OUT_VALID & OUT_READY;
    assign in_entry = {IN_RESULT, IN_NEGATIVE, IN_ZERO, IN_CARRY, IN_OVERFLOW};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !deliver) begin
                    state_d = ST_FULL;
                end else if (!accept && deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (deliver) begin
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        IN_READY  = 1'b1;
        OUT_VALID = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                IN_READY  = 1'b1;
                OUT_VALID = 1'b0;
            end
            ST_ONE: begin
                IN_READY  = 1'b1;
                OUT_VALID = 1'b1;
            end
            ST_FULL: begin
                IN_READY  = 1'b0;
                OUT_VALID = 1'b1;
            end
            default: begin
                IN_READY  = 1'b1;
                OUT_VALID = 1'b0;
            end
        endcase
    end

    // The head is zeroed when it drains, so the outputs read 0 whenever the stage is empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_q <= in_entry;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        head_q <= in_entry;
                    end else if (accept) begin
                        skid_q <= in_entry;
                    end else if (deliver) begin
                        head_q <= '0;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        head_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    head_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    // Status follows accepted results, not delivered ones, so back-pressure never delays it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_q <= 4'b0000;
        end else if (accept && IN_UPDATE_FLAGS) begin
            status_q <= {IN_NEGATIVE, IN_ZERO, IN_CARRY, IN_OVERFLOW};
        end
    end

    // If a set and a clear arrive in the same cycle, the set wins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sticky_q <= 1'b0;
        end else if (accept && IN_UPDATE_FLAGS && IN_OVERFLOW) begin
            sticky_q <= 1'b1;
        end else if (CLEAR_STICKY) begin
            sticky_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (deliver) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign OUT_RESULT      = head_q[EW-1:4];
    assign OUT_FLAGS       = head_q[3:0];
    assign STATUS_NZCV     = status_q;
    assign STICKY_OVERFLOW = sticky_q;
    assign RESULT_COUNT    = count_q;
    assign DEBUG_STATE     = state_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage. A queue-based model of a depth-2 FIFO with status, sticky and count
// tracks the expected behaviour while directed and random scenarios run against the design.
module tb_alu_result_stage;

    localparam int N = 4;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [N-1:0]  IN_RESULT = '0;
    logic          IN_CARRY = 1'b0;
    logic          IN_OVERFLOW = 1'b0;
    logic          IN_NEGATIVE = 1'b0;
    logic          IN_ZERO = 1'b0;
    logic          IN_UPDATE_FLAGS = 1'b0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [N-1:0]  OUT_RESULT;
    logic [3:0]    OUT_FLAGS;
    logic [3:0]    STATUS_NZCV;
    logic          STICKY_OVERFLOW;
    logic          CLEAR_STICKY = 1'b0;
    logic [CW-1:0] RESULT_COUNT;
    logic [1:0]    DEBUG_STATE;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model
    logic [N+3:0]  exp_q[$];
    logic [3:0]    m_status;
    logic          m_sticky;
    logic [CW-1:0] m_count;

    alu_result_stage #(.Nbits(N), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_RESULT(IN_RESULT),
        .IN_CARRY(IN_CARRY), .IN_OVERFLOW(IN_OVERFLOW), .IN_NEGATIVE(IN_NEGATIVE),
        .IN_ZERO(IN_ZERO), .IN_UPDATE_FLAGS(IN_UPDATE_FLAGS),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
        .OUT_FLAGS(OUT_FLAGS), .STATUS_NZCV(STATUS_NZCV), .STICKY_OVERFLOW(STICKY_OVERFLOW),
        .CLEAR_STICKY(CLEAR_STICKY), .RESULT_COUNT(RESULT_COUNT), .DEBUG_STATE(DEBUG_STATE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [N-1:0] exp_res();
        return (exp_q.size() > 0) ? exp_q[0][N+3:4] : '0;
    endfunction

    function automatic logic [3:0] exp_flags();
        return (exp_q.size() > 0) ? exp_q[0][3:0] : 4'b0000;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_status = 4'b0000;
        m_sticky = 1'b0;
        m_count  = '0;
    endtask

    task automatic do_reset();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        CLEAR_STICKY = 1'b0;
        IN_UPDATE_FLAGS = 1'b0;
        RESET = 1'b1;
        model_clear();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    // Called 1 time unit after a rising edge. It drives one cycle of inputs, advances the model across
    // the next edge, and returns 1 time unit after that edge.
    task automatic drive(input logic v, input logic [N-1:0] res, input logic [3:0] nzcv,
                         input logic upd, input logic ordy, input logic clr);
        logic m_acc;
        logic m_del;
        IN_VALID        = v;
        IN_RESULT       = v ? res : 'x;
        IN_NEGATIVE     = v ? nzcv[3] : 1'bx;
        IN_ZERO         = v ? nzcv[2] : 1'bx;
        IN_CARRY        = v ? nzcv[1] : 1'bx;
        IN_OVERFLOW     = v ? nzcv[0] : 1'bx;
        IN_UPDATE_FLAGS = upd;
        OUT_READY       = ordy;
        CLEAR_STICKY    = clr;
        m_acc = v && (exp_q.size() < 2);
        m_del = ordy && (exp_q.size() > 0);
        @(posedge CLK);
        if (m_del) exp_q.delete(0);
        if (m_acc) exp_q.push_back({res, nzcv});
        if (m_acc && upd) m_status = nzcv;
        if (m_acc && upd && nzcv[0]) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        if (m_del) m_count = m_count + 1'b1;
        #1;
        IN_VALID = 1'b0;
        CLEAR_STICKY = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
        n_cmp++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
        n_cmp++; if ({OUT_RESULT, OUT_FLAGS} !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h/%b want=0/0", OUT_RESULT, OUT_FLAGS); end
        n_cmp++; if ({STATUS_NZCV, STICKY_OVERFLOW} !== 5'b0) begin n_fail++; $display("FAIL reset_status got=%b/%b want=0000/0", STATUS_NZCV, STICKY_OVERFLOW); end
        n_cmp++; if (RESULT_COUNT !== '0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", RESULT_COUNT); end
    endtask

    task automatic test_single();
        drive(1'b1, 4'h9, 4'b1011, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b want=1", OUT_VALID); end
        n_cmp++; if (OUT_RESULT !== 4'h9) begin n_fail++; $display("FAIL single_result got=%h want=9", OUT_RESULT); end
        n_cmp++; if (OUT_FLAGS !== 4'b1011) begin n_fail++; $display("FAIL single_flags got=%b want=1011", OUT_FLAGS); end
        n_cmp++; if (STATUS_NZCV !== 4'b1011) begin n_fail++; $display("FAIL single_status got=%b want=1011", STATUS_NZCV); end
        n_cmp++; if (STICKY_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL single_sticky got=%b want=1", STICKY_OVERFLOW); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (RESULT_COUNT !== 8'd1) begin n_fail++; $display("FAIL single_count got=%0d want=1", RESULT_COUNT); end
        n_cmp++; if (OUT_VALID !== 1'b0 || OUT_RESULT !== 4'h0) begin n_fail++; $display("FAIL single_drain got=%b/%h want=0/0", OUT_VALID, OUT_RESULT); end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 4'h3, 4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%b want=1", IN_READY); end
        drive(1'b1, 4'h5, 4'b0100, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got=%b want=0", IN_READY); end
        n_cmp++; if (OUT_RESULT !== 4'h3) begin n_fail++; $display("FAIL bp_hold got=%h want=3", OUT_RESULT); end
        drive(1'b1, 4'h6, 4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (OUT_RESULT !== 4'h3 || IN_READY !== 1'b0) begin n_fail++; $display("FAIL bp_hold2 got=%h/%b want=3/0", OUT_RESULT, IN_READY); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (OUT_RESULT !== 4'h5 || OUT_FLAGS !== 4'b0100) begin n_fail++; $display("FAIL bp_second got=%h/%b want=5/0100", OUT_RESULT, OUT_FLAGS); end
        n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b want=1", IN_READY); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (OUT_VALID !== 1'b0 || RESULT_COUNT !== 8'd2) begin n_fail++; $display("FAIL bp_end got=%b/%0d want=0/2", OUT_VALID, RESULT_COUNT); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, N'(i), 4'(i), 1'b0, 1'b1, 1'b0);
            n_cmp++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== N'(i)) begin n_fail++; $display("FAIL stream_out[%0d] got=%b/%h want=1/%h", i, OUT_VALID, OUT_RESULT, N'(i)); end
            n_cmp++; if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b want=1", i, IN_READY); end
        end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (RESULT_COUNT !== 8'd20) begin n_fail++; $display("FAIL stream_count got=%0d want=20", RESULT_COUNT); end
    endtask

    task automatic test_flags();
        do_reset();
        drive(1'b1, 4'h1, 4'b0110, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 4'h2, 4'b1001, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (STATUS_NZCV !== 4'b0110) begin n_fail++; $display("FAIL flags_gated_status got=%b want=0110", STATUS_NZCV); end
        n_cmp++; if (STICKY_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL flags_gated_sticky got=%b want=0", STICKY_OVERFLOW); end
        n_cmp++; if (OUT_FLAGS !== 4'b1001) begin n_fail++; $display("FAIL flags_carried got=%b want=1001", OUT_FLAGS); end
        drive(1'b1, 4'h3, 4'b0001, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (STICKY_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL flags_set_wins got=%b want=1", STICKY_OVERFLOW); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (STICKY_OVERFLOW !== 1'b1) begin n_fail++; $display("FAIL flags_sticky_hold got=%b want=1", STICKY_OVERFLOW); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (STICKY_OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL flags_clear got=%b want=0", STICKY_OVERFLOW); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) drive(1'b1, N'(i), 4'b0000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (RESULT_COUNT !== 8'd0) begin n_fail++; $display("FAIL wrap_256 got=%0d want=0", RESULT_COUNT); end
        drive(1'b1, 4'h4, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (RESULT_COUNT !== 8'd1) begin n_fail++; $display("FAIL wrap_257 got=%0d want=1", RESULT_COUNT); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b1, 4'h7, 4'b1000, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 4'b0011, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (IN_READY !== 1'b0 || OUT_RESULT !== 4'h7) begin n_fail++; $display("FAIL mid_full got=%b/%h want=0/7", IN_READY, OUT_RESULT); end
        #2 RESET = 1'b1;
        model_clear();
        #1;
        n_cmp++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin n_fail++; $display("FAIL mid_async_hs got=%b/%b want=0/1", OUT_VALID, IN_READY); end
        n_cmp++; if ({OUT_RESULT, OUT_FLAGS} !== '0) begin n_fail++; $display("FAIL mid_async_data got=%h/%b want=0/0", OUT_RESULT, OUT_FLAGS); end
        n_cmp++; if ({STATUS_NZCV, STICKY_OVERFLOW} !== 5'b0) begin n_fail++; $display("FAIL mid_async_status got=%b/%b want=0000/0", STATUS_NZCV, STICKY_OVERFLOW); end
        @(posedge CLK);
        #1 RESET = 1'b0;
        drive(1'b1, 4'hA, 4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (OUT_VALID !== 1'b1 || OUT_RESULT !== 4'hA) begin n_fail++; $display("FAIL mid_first got=%b/%h want=1/a", OUT_VALID, OUT_RESULT); end
        drive(1'b0, '0, 4'b0000, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (OUT_VALID !== 1'b0 || OUT_RESULT !== 4'h0) begin n_fail++; $display("FAIL mid_no_stale got=%b/%h want=0/0", OUT_VALID, OUT_RESULT); end
        n_cmp++; if (RESULT_COUNT !== 8'd1) begin n_fail++; $display("FAIL mid_count got=%0d want=1", RESULT_COUNT); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), N'($urandom), 4'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            n_cmp++; if (IN_READY !== (exp_q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, IN_READY, exp_q.size() < 2); end
            n_cmp++; if (OUT_VALID !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, OUT_VALID, exp_q.size() > 0); end
            n_cmp++; if (OUT_RESULT !== exp_res() || OUT_FLAGS !== exp_flags()) begin n_fail++; $display("FAIL rnd_data[%0d] got=%h/%b want=%h/%b", i, OUT_RESULT, OUT_FLAGS, exp_res(), exp_flags()); end
            n_cmp++; if (STATUS_NZCV !== m_status || STICKY_OVERFLOW !== m_sticky) begin n_fail++; $display("FAIL rnd_status[%0d] got=%b/%b want=%b/%b", i, STATUS_NZCV, STICKY_OVERFLOW, m_status, m_sticky); end
            n_cmp++; if (RESULT_COUNT !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", i, RESULT_COUNT, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_flags();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the N-bit combinational ALU.
- Captures the ALU result and its four flags under a valid/ready handshake and buffers them in a 2-entry skid buffer, so back-pressure never stalls the ALU combinationally.
- Maintains the architectural NZCV status register, a sticky overflow bit and a delivered-result counter for the datapath consumer.

Parameters:
Nbits, 4, ALU data width; must match the upstream ALU.
CNT_W, 8, width of the delivered-result counter.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
IN_VALID  input  1  upstream result valid.
IN_READY  output  1  stage can accept this cycle.
IN_RESULT  input  Nbits  ALU result.
IN_CARRY  input  1  ALU carry flag.
IN_OVERFLOW  input  1  ALU overflow flag.
IN_NEGATIVE  input  1  ALU negative flag.
IN_ZERO  input  1  ALU zero flag.
IN_UPDATE_FLAGS  input  1  this result updates the status register.
OUT_VALID  output  1  head entry valid.
OUT_READY  input  1  downstream accepts the head entry.
OUT_RESULT  output  Nbits  head entry result.
OUT_FLAGS  output  4  head entry flags, ordered {N,Z,C,V}.
STATUS_NZCV  output  4  architectural status register, ordered {N,Z,C,V}.
STICKY_OVERFLOW  output  1  set by any flag-updating overflow; held until cleared.
CLEAR_STICKY  input  1  synchronous clear of STICKY_OVERFLOW.
RESULT_COUNT  output  CNT_W  number of entries delivered downstream.

Behaviour:
- Handshakes:
  - accept = IN_VALID & IN_READY.
  - deliver = OUT_VALID & OUT_READY.
- Storage: head register (drives OUT_*) and one skid register. Entry = {result, N, Z, C, V}, Nbits+4 bits.
- FSM states:
  - EMPTY: OUT_VALID=0, IN_READY=1.
  - ONE: OUT_VALID=1, IN_READY=1.
  - FULL: OUT_VALID=1, IN_READY=0.
- FSM transitions:
  - EMPTY: accept -> ONE (entry into head).
  - ONE: accept & !deliver -> FULL (entry into skid). accept & deliver -> ONE (head replaced by new entry). !accept & deliver -> EMPTY. Otherwise hold.
  - FULL: deliver -> ONE (skid moves to head). Otherwise hold. No accept is possible in FULL.
- IN_READY and OUT_VALID are pure decodes of the state register; no combinational path from OUT_READY to IN_READY.
- Latency: accept in cycle t -> OUT_VALID=1 with that entry in cycle t+1 (state EMPTY or ONE with simultaneous deliver).
- Order is strictly FIFO; no entry is dropped or duplicated.
- OUT_RESULT and OUT_FLAGS hold their value while OUT_VALID & !OUT_READY.
- OUT_RESULT and OUT_FLAGS are 0 when in EMPTY.
- Status register:
  - On accept with IN_UPDATE_FLAGS=1, STATUS_NZCV <= {IN_NEGATIVE, IN_ZERO, IN_CARRY, IN_OVERFLOW} at that edge, independent of downstream back-pressure.
  - Accept with IN_UPDATE_FLAGS=0 leaves STATUS_NZCV unchanged.
- Sticky overflow:
  - Set on accept & IN_UPDATE_FLAGS & IN_OVERFLOW.
  - CLEAR_STICKY clears it.
  - Set and clear in the same cycle -> set wins (result 1).
- RESULT_COUNT increments by 1 on each deliver and wraps from 2^CNT_W-1 to 0.
- IN_* values are ignored when not accepted; X on IN_RESULT with IN_VALID=0 must not propagate.
- Reset: asynchronous assert, any cycle including mid-transfer.
  - Immediately: state EMPTY, both entries cleared, OUT_VALID=0, IN_READY=1, OUT_RESULT=0, OUT_FLAGS=0, STATUS_NZCV=0, STICKY_OVERFLOW=0, RESULT_COUNT=0.
  - Buffered entries are discarded.
  - First accept is possible on the first rising edge after RESET deasserts.

Test Plan:
- Reset then single transfer, Nbits=4, OUT_READY=1: IN_RESULT=4'h9, flags N=1 Z=0 C=1 V=1, UPDATE=1 in cycle 0 -> cycle 1: OUT_VALID=1, OUT_RESULT=9, OUT_FLAGS=4'b1011, STATUS_NZCV=4'b1011, STICKY_OVERFLOW=1; cycle 2: RESULT_COUNT=1.
- Back-pressure, OUT_READY=0: accept 3 then 5 -> IN_READY=0 after the second accept, OUT_RESULT holds 3. Raise OUT_READY -> outputs 3 then 5, IN_READY returns to 1 after the first deliver.
- Streaming, IN_VALID=OUT_READY=1 for 20 cycles with values 0..19 -> outputs 0..19 in order one per cycle after 1-cycle latency, state never FULL, RESULT_COUNT=20.
- Flag gating: accept V=1 with UPDATE=0 -> STATUS_NZCV and STICKY_OVERFLOW unchanged. Same cycle CLEAR_STICKY=1 and an updating overflow -> STICKY_OVERFLOW=1 next cycle.
- Wrap, CNT_W=8: 256 delivers -> RESULT_COUNT=0; 257 delivers -> 1.
- Mid-operation reset: in FULL with entries 7 and 2, assert RESET between edges -> outputs go to reset values without waiting for an edge. Then accept 4'hA -> OUT_RESULT=A; 7 and 2 never appear.
